// File: rtl/jtkicker_sdram_arb_pkg.sv
// Shared definitions for the jtkicker SDRAM read arbiter.
// Holds the slot numbering, the request FSM state type and the
// arbitration helpers used by the top level.
package jtkicker_sdram_arb_pkg;

  localparam int NSLOT     = 4;
  localparam int SLOT_MAIN = 0;
  localparam int SLOT_SCR  = 1;
  localparam int SLOT_OBJ  = 2;
  localparam int SLOT_PCM  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Winner among missing slots: main always first, then slots 1..3
  // in circular order beginning at the round-robin pointer.
  function automatic logic [1:0] arb_pick(input logic [3:0] miss, input logic [1:0] ptr);
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] pick;
    case (ptr)
      2'd2: begin
        c0 = 2'(SLOT_OBJ); c1 = 2'(SLOT_PCM); c2 = 2'(SLOT_SCR);
      end
      2'd3: begin
        c0 = 2'(SLOT_PCM); c1 = 2'(SLOT_SCR); c2 = 2'(SLOT_OBJ);
      end
      default: begin
        c0 = 2'(SLOT_SCR); c1 = 2'(SLOT_OBJ); c2 = 2'(SLOT_PCM);
      end
    endcase
    if (miss[SLOT_MAIN]) begin
      pick = 2'(SLOT_MAIN);
    end else if (miss[c0]) begin
      pick = c0;
    end else if (miss[c1]) begin
      pick = c1;
    end else begin
      pick = c2;
    end
    return pick;
  endfunction

  // Pointer value after granting one of slots 1..3: the slot just past it.
  function automatic logic [1:0] rr_next(input logic [1:0] slot);
    logic [1:0] nxt;
    if (slot == 2'(SLOT_PCM)) begin
      nxt = 2'(SLOT_SCR);
    end else begin
      nxt = slot + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/jtkicker_sdram_arb_if.sv
// Bus bundle between the ROM consumers / SDRAM controller and the arbiter.
//   slave  : arbiter side (consumes slot requests and SDRAM responses)
//   master : environment side (game ROM users plus SDRAM controller)
// Signals: downloading, slot_cs[4], slot_addr[4*AW], slot_ok[4],
//          slot_dout[64], sdram_req, sdram_addr[AW], sdram_ack,
//          data_rdy, data_read[16], gnt[2] (debug).
interface jtkicker_sdram_arb_if #(
  parameter int AW = 22
);
  logic              downloading;
  logic [3:0]        slot_cs;
  logic [4*AW-1:0]   slot_addr;
  logic [3:0]        slot_ok;
  logic [63:0]       slot_dout;
  logic              sdram_req;
  logic [AW-1:0]     sdram_addr;
  logic              sdram_ack;
  logic              data_rdy;
  logic [15:0]       data_read;
  logic [1:0]        gnt;

  modport slave (
    input  downloading, slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    output slot_ok, slot_dout, sdram_req, sdram_addr, gnt
  );

  modport master (
    output downloading, slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    input  slot_ok, slot_dout, sdram_req, sdram_addr, gnt
  );
endinterface

// File: rtl/jtkicker_sdram_arb_slot.sv
// One-word tagged cache for a single ROM requester.
// Ports:
//   clk, rst_n     clock and async active-low reset
//   i_cs, i_addr   requester strobe and word address
//   i_fill         write tag/data from the finishing SDRAM read
//   i_set_valid    the fill may mark the entry valid
//   i_inval        clear the valid bit (wins over a fill)
//   i_fill_tag/_data  latched request address and returned word
//   o_ok, o_miss   hit / miss for the current address
//   o_dout         cached word
module jtkicker_sdram_arb_slot #(
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cs,
  input  logic [AW-1:0] i_addr,
  input  logic          i_fill,
  input  logic          i_set_valid,
  input  logic          i_inval,
  input  logic [AW-1:0] i_fill_tag,
  input  logic [15:0]   i_fill_data,
  output logic          o_ok,
  output logic          o_miss,
  output logic [15:0]   o_dout
);

  logic [AW-1:0] r_tag;
  logic [15:0]   r_data;
  logic          r_valid;

  // Cache entry: tag/data written on every fill, valid gated separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag   <= '0;
      r_data  <= 16'h0000;
      r_valid <= 1'b0;
    end else begin
      if (i_fill) begin
        r_tag  <= i_fill_tag;
        r_data <= i_fill_data;
      end
      if (i_inval) begin
        r_valid <= 1'b0;
      end else if (i_fill && i_set_valid) begin
        r_valid <= 1'b1;
      end
    end
  end

  // Hit is zero-latency: combinational on the live address.
  assign o_ok   = i_cs & r_valid & (r_tag == i_addr);
  assign o_miss = i_cs & ~o_ok;
  assign o_dout = r_data;

endmodule

// File: rtl/jtkicker_sdram_arb.sv
// SDRAM read arbiter sharing one 16-bit read port among four ROM users
// (main, scroll, objects, PCM), each fronted by a one-word cache.
// Ports:
//   clk    system clock
//   rst_n  async active-low reset
//   bus    jtkicker_sdram_arb_if.slave: slot requests/results, SDRAM
//          request/ack/data, download flag and debug grant index
module jtkicker_sdram_arb
  import jtkicker_sdram_arb_pkg::*;
#(
  parameter int          AW      = 22,
  parameter int unsigned OFFSET0 = 0,
  parameter int unsigned OFFSET1 = 0,
  parameter int unsigned OFFSET2 = 0,
  parameter int unsigned OFFSET3 = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  jtkicker_sdram_arb_if.slave bus
);

  logic [AW-1:0]    w_addr [NSLOT];
  logic [AW-1:0]    w_off  [NSLOT];
  logic [15:0]      w_dout [NSLOT];
  logic [NSLOT-1:0] w_ok;
  logic [NSLOT-1:0] w_miss;
  logic [NSLOT-1:0] w_fill;
  logic [1:0]       w_win;
  logic             w_any_miss;
  logic             w_fill_done;
  logic             w_set_valid;

  state_t           r_state;
  logic [1:0]       r_gnt;
  logic [1:0]       r_rr;
  logic [AW-1:0]    r_req_tag;
  logic [AW-1:0]    r_sdram_addr;
  logic             r_req;
  logic             r_dl_seen;

  assign w_off[0] = AW'(OFFSET0);
  assign w_off[1] = AW'(OFFSET1);
  assign w_off[2] = AW'(OFFSET2);
  assign w_off[3] = AW'(OFFSET3);

  assign w_any_miss  = |w_miss;
  assign w_win       = arb_pick(w_miss, r_rr);
  assign w_fill_done = (r_state == WAIT) && bus.data_rdy;
  // A read that overlapped a download may carry stale ROM data, so it
  // never becomes valid even if the download ended before the data came.
  assign w_set_valid = !bus.downloading && !r_dl_seen;

  for (genvar n = 0; n < NSLOT; n++) begin : g_slot
    assign w_addr[n] = bus.slot_addr[n*AW +: AW];
    assign w_fill[n] = w_fill_done && (r_gnt == 2'(n));

    jtkicker_sdram_arb_slot #(
      .AW (AW)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_cs        (bus.slot_cs[n]),
      .i_addr      (w_addr[n]),
      .i_fill      (w_fill[n]),
      .i_set_valid (w_set_valid),
      .i_inval     (bus.downloading),
      .i_fill_tag  (r_req_tag),
      .i_fill_data (bus.data_read),
      .o_ok        (w_ok[n]),
      .o_miss      (w_miss[n]),
      .o_dout      (w_dout[n])
    );
  end

  // Request FSM: arbitration, SDRAM handshake and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_gnt        <= 2'd0;
      r_rr         <= 2'(SLOT_SCR);
      r_req_tag    <= '0;
      r_sdram_addr <= '0;
      r_req        <= 1'b0;
      r_dl_seen    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.downloading && w_any_miss) begin
            r_gnt        <= w_win;
            r_req_tag    <= w_addr[w_win];
            r_sdram_addr <= w_addr[w_win] + w_off[w_win];
            r_req        <= 1'b1;
            r_dl_seen    <= 1'b0;
            r_state      <= REQ;
            // Main bypasses the rotation and leaves the pointer alone.
            if (w_win != 2'(SLOT_MAIN)) begin
              r_rr <= rr_next(w_win);
            end
          end
        end
        REQ: begin
          if (bus.downloading) begin
            r_dl_seen <= 1'b1;
          end
          if (bus.sdram_ack) begin
            r_req   <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.downloading) begin
            r_dl_seen <= 1'b1;
          end
          if (bus.data_rdy) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.slot_ok    = w_ok;
  assign bus.slot_dout  = {w_dout[3], w_dout[2], w_dout[1], w_dout[0]};
  assign bus.sdram_req  = r_req;
  assign bus.sdram_addr = r_sdram_addr;
  assign bus.gnt        = r_gnt;

endmodule

// File: tb/tb_jtkicker_sdram_arb.sv
// Self-checking bench for jtkicker_sdram_arb: directed scenarios followed
// by random traffic, all compared against a transaction-level cache model.
module tb_jtkicker_sdram_arb;

  localparam int          AW   = 22;
  localparam int unsigned OFF0 = 32'h0000_0000;
  localparam int unsigned OFF1 = 32'h0000_0200;
  localparam int unsigned OFF2 = 32'h0001_0000;
  localparam int unsigned OFF3 = 32'h003F_FF00;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jtkicker_sdram_arb_if #(.AW(AW)) bus ();

  jtkicker_sdram_arb #(
    .AW(AW), .OFFSET0(OFF0), .OFFSET1(OFF1), .OFFSET2(OFF2), .OFFSET3(OFF3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // stimulus owned by the bench
  logic [3:0]    s_cs;
  logic [AW-1:0] s_addr [4];
  logic          s_dl, s_ack, s_rdy;
  logic [15:0]   s_data;

  // reference model: cache contents plus the one outstanding read
  logic          m_valid [4];
  logic [AW-1:0] m_tag   [4];
  logic [15:0]   m_data  [4];
  logic [AW-1:0] m_off   [4];
  int            m_ptr;
  bit            m_busy, m_acked, m_taint;
  int            m_slot;
  logic [AW-1:0] m_reqtag, m_out_addr;

  int n_checks = 0;
  int n_errors = 0;
  int gnt_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_valid[n] = 1'b0; m_tag[n] = '0; m_data[n] = 16'h0000;
    end
    m_ptr = 1; m_busy = 0; m_acked = 0; m_taint = 0; m_slot = 0;
    m_reqtag = '0; m_out_addr = '0;
  endtask

  // Advance the model by one clock using the inputs of the cycle just ended.
  task automatic model_edge();
    logic [3:0] miss;
    int win;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int n = 0; n < 4; n++)
      miss[n] = s_cs[n] && !(m_valid[n] && m_tag[n] == s_addr[n]);
    if (!m_busy) begin
      if (!s_dl && miss != 4'b0000) begin
        win = -1;
        if (miss[0]) win = 0;
        else begin
          for (int k = 0; k < 3; k++) begin
            int s;
            s = 1 + ((m_ptr - 1 + k) % 3);
            if (win < 0 && miss[s]) win = s;
          end
          m_ptr = 1 + (win % 3);
        end
        m_busy = 1; m_acked = 0; m_taint = 0; m_slot = win;
        m_reqtag = s_addr[win];
        m_out_addr = s_addr[win] + m_off[win];
      end
    end else if (!m_acked) begin
      if (s_dl) m_taint = 1;
      if (s_ack) m_acked = 1;
    end else begin
      if (s_dl) m_taint = 1;
      if (s_rdy) begin
        m_data[m_slot] = s_data;
        m_tag[m_slot]  = m_reqtag;
        if (!s_dl && !m_taint) m_valid[m_slot] = 1'b1;
        m_busy = 0;
      end
    end
    if (s_dl) for (int n = 0; n < 4; n++) m_valid[n] = 1'b0;
  endtask

  task automatic drive();
    bus.slot_cs     = s_cs;
    bus.slot_addr   = {s_addr[3], s_addr[2], s_addr[1], s_addr[0]};
    bus.downloading = s_dl;
    bus.sdram_ack   = s_ack;
    bus.data_rdy    = s_rdy;
    bus.data_read   = s_data;
  endtask

  task automatic check_all();
    logic [3:0]  eok;
    logic [63:0] edout;
    for (int n = 0; n < 4; n++) begin
      eok[n] = s_cs[n] && m_valid[n] && (m_tag[n] == s_addr[n]);
      edout[n*16 +: 16] = m_data[n];
    end
    check("sdram_req",  bus.sdram_req,  m_busy && !m_acked);
    check("sdram_addr", bus.sdram_addr, m_out_addr);
    check("gnt",        bus.gnt,        m_slot);
    check("slot_ok",    bus.slot_ok,    eok);
    check("slot_dout",  bus.slot_dout,  edout);
  endtask

  // One clock: apply inputs, check mid-cycle, then step the model at the edge.
  task automatic tick();
    drive();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    s_cs = 4'b0000; s_dl = 1'b0; s_ack = 1'b0; s_rdy = 1'b0; s_data = 16'h0000;
    for (int n = 0; n < 4; n++) s_addr[n] = '0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output int g);
    int guard;
    guard = 0;
    while (bus.sdram_req !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check("req_within_budget", bus.sdram_req, 1'b1);
    g = int'(bus.gnt);
    gnt_log.push_back(g);
  endtask

  task automatic finish_txn(input int ack_dly, input int rdy_dly, input logic [15:0] d);
    repeat (ack_dly) tick();
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    repeat (rdy_dly) tick();
    s_data = d; s_rdy = 1'b1; tick(); s_rdy = 1'b0;
  endtask

  task automatic serve(input logic [15:0] d);
    int g;
    wait_req(g);
    finish_txn(1, 2, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int cnt[4];
    int exp_prio[4];
    int dl_cnt;
    m_off[0] = AW'(OFF0); m_off[1] = AW'(OFF1); m_off[2] = AW'(OFF2); m_off[3] = AW'(OFF3);
    rst_n = 1'b1;
    #1;
    reset_dut();
    tick();

    // single miss with offset, then hits with no traffic
    s_cs = 4'b0100; s_addr[2] = 22'h00_0040;
    tick();
    check("single_req_t1", bus.sdram_req, 1'b1);
    check("single_addr", bus.sdram_addr, 22'h01_0040);
    check("single_gnt", bus.gnt, 2'd2);
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    check("single_req_drop", bus.sdram_req, 1'b0);
    tick();
    s_rdy = 1'b1; s_data = 16'hBEEF; tick(); s_rdy = 1'b0;
    check("single_ok", bus.slot_ok[2], 1'b1);
    check("single_dout", bus.slot_dout[47:32], 16'hBEEF);
    repeat (5) begin
      tick();
      check("single_no_refetch", bus.sdram_req, 1'b0);
    end

    // priority: main re-misses while slot 1 is in flight -> 0,1,0,3
    reset_dut();
    gnt_log.delete();
    s_cs = 4'b1011; s_addr[0] = 22'h10; s_addr[1] = 22'h20; s_addr[3] = 22'h30;
    serve(16'h1111);
    wait_req(g);
    s_addr[0] = 22'h11;
    finish_txn(1, 1, 16'h2222);
    serve(16'h3333);
    serve(16'h4444);
    exp_prio = '{0, 1, 0, 3};
    check("prio_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      check($sformatf("prio_order%0d", i), gnt_log[i], exp_prio[i]);
    check("prio_all_hit", bus.slot_ok, 4'b1011);

    // round-robin fairness over slots 1..3
    reset_dut();
    gnt_log.delete();
    s_cs = 4'b1110; s_addr[1] = 22'h100; s_addr[2] = 22'h200; s_addr[3] = 22'h300;
    for (int t = 0; t < 9; t++) begin
      wait_req(g);
      finish_txn(0, 1, 16'(t));
      s_addr[1 + t % 3] = s_addr[1 + t % 3] + 22'h1;
    end
    cnt = '{0, 0, 0, 0};
    for (int t = 0; t < gnt_log.size(); t++) begin
      check($sformatf("rr_order%0d", t), gnt_log[t], 1 + t % 3);
      if (gnt_log[t] >= 0 && gnt_log[t] < 4) cnt[gnt_log[t]]++;
    end
    for (int s = 1; s < 4; s++) check($sformatf("rr_count%0d", s), cnt[s], 3);

    // address change during WAIT
    reset_dut();
    s_cs = 4'b0010; s_addr[1] = 22'h100;
    wait_req(g);
    check("chg_first_addr", bus.sdram_addr, 22'h300);
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    s_addr[1] = 22'h200; tick();
    s_data = 16'hA5A5; s_rdy = 1'b1; tick(); s_rdy = 1'b0;
    check("chg_ok_stays0", bus.slot_ok[1], 1'b0);
    s_addr[1] = 22'h100; drive(); #1;
    check("chg_return_hit", bus.slot_ok[1], 1'b1);
    tick();
    s_addr[1] = 22'h200;
    wait_req(g);
    check("chg_second_addr", bus.sdram_addr, 22'h400);
    finish_txn(0, 0, 16'h5A5A);
    check("chg_second_ok", bus.slot_ok[1], 1'b1);

    // download: fill all, then 5 download cycles overlapping a WAIT
    reset_dut();
    s_cs = 4'b1111;
    for (int n = 0; n < 4; n++) s_addr[n] = 22'(32'h1000 + n * 32'h100);
    repeat (4) serve(16'($urandom));
    check("dl_filled", bus.slot_ok, 4'hF);
    s_addr[3] = 22'h1301;
    wait_req(g);
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    s_dl = 1'b1; tick();
    check("dl_req_low", bus.sdram_req, 1'b0);
    s_rdy = 1'b1; s_data = 16'hC0DE; tick(); s_rdy = 1'b0;
    repeat (3) begin
      tick();
      check("dl_req_low", bus.sdram_req, 1'b0);
      check("dl_all_invalid", bus.slot_ok, 4'h0);
    end
    s_dl = 1'b0; tick();
    check("dl_resume_req", bus.sdram_req, 1'b1);
    finish_txn(0, 1, 16'h0F0F);

    // async reset while a request is pending
    s_cs = 4'b0001; s_addr[0] = 22'h2000;
    wait_req(g);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_req", bus.sdram_req, 1'b0);
    model_reset();
    tick();
    rst_n = 1'b1;
    s_cs = 4'hF; drive(); #1;
    check("rst_valid_cleared", bus.slot_ok, 4'h0);
    tick();

    // random traffic against the model
    dl_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(0, 9) == 0) s_addr[n] = AW'(n * 256 + $urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) s_cs[n] = ~s_cs[n];
      end
      s_ack  = ($urandom_range(0, 3) == 0);
      s_rdy  = ($urandom_range(0, 3) == 0);
      s_data = 16'($urandom);
      if (dl_cnt > 0) dl_cnt--;
      else if ($urandom_range(0, 99) == 0) dl_cnt = $urandom_range(1, 5);
      s_dl = (dl_cnt > 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/jtkicker_sdram_arb.md
# jtkicker_sdram_arb

SDRAM read arbiter that shares the single 16-bit SDRAM read port among four ROM requesters: main CPU, scroll tiles, objects and PCM. Each requester gets a one-word tagged cache, so repeated reads of the same word are served without SDRAM traffic. It sits between the game-level ROM consumers and the framework SDRAM controller, in the `clk` domain. Requests are blocked while ROM download is active.

## Interface

Parameters:
- `AW`, 22: SDRAM word-address width.
- `OFFSET0`, 0: word offset added to slot 0 (main) addresses.
- `OFFSET1`, 0: word offset added to slot 1 (scroll) addresses.
- `OFFSET2`, 0: word offset added to slot 2 (objects) addresses.
- `OFFSET3`, 0: word offset added to slot 3 (PCM) addresses.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `downloading`  in  1  ROM download in progress.
- `slot_cs`  in  4  per-slot request; bit n belongs to slot n.
- `slot_addr`  in  4*AW  per-slot word address; slot n uses bits [n*AW +: AW].
- `slot_ok`  out  4  per-slot data valid for the current address.
- `slot_dout`  out  64  per-slot cached word; slot n uses bits [n*16 +: 16].
- `sdram_req`  out  1  read request to the SDRAM controller.
- `sdram_addr`  out  AW  request address.
- `sdram_ack`  in  1  controller accepted the request.
- `data_rdy`  in  1  `data_read` is valid this cycle.
- `data_read`  in  16  SDRAM read data.
- `gnt`  out  2  index of the slot being served; debug only.

## Operation
- Per slot, registers `tag` (AW bits), `data` (16 bits) and `valid`.
- `slot_ok[n]` = `slot_cs[n]` & `valid[n]` & (`tag[n]` == addr n). This is combinational from registers and inputs.
- A slot misses when `slot_cs[n]` is high and `slot_ok[n]` is low.
- FSM states:
  - IDLE: if not `downloading` and any slot misses, arbitrate, latch the winner into `gnt`, latch the address into `req_tag`, drive `sdram_addr` = addr + OFFSETn (mod 2^AW), and go to REQ.
  - REQ: `sdram_req` is held at 1. On `sdram_ack`, go to WAIT.
  - WAIT: `sdram_req` is 0. On `data_rdy`, write `data[gnt]` = `data_read`, `tag[gnt]` = `req_tag` and `valid[gnt]` = 1, then go to IDLE.
- Arbitration:
  - Slot 0 always wins if it misses.
  - Otherwise slots 1–3 are served round-robin. The pointer starts at slot 1 and moves past the last granted slot from 1–3.
  - An active transaction is never aborted.
- A `cs` drop or address change during REQ/WAIT does not abort the transaction. The fill is still written with the latched `req_tag`, so it counts as a hit only if the address returns to that value.
- `downloading`:
  - While high, no new requests are issued.
  - Every cycle it is high clears all `valid` bits.
  - An in-flight transaction completes normally but its fill does not set `valid`.
- `sdram_ack` outside REQ is ignored. `data_rdy` outside WAIT is ignored.

## Timing
- Reset values: `sdram_req`=0, `sdram_addr`=0, `gnt`=0, all `valid`=0, all `slot_ok`=0, `slot_dout`=0, FSM in IDLE, round-robin pointer at slot 1.
- A reset during REQ/WAIT drops `sdram_req` immediately (async) and discards the transaction.
- A miss seen in cycle T gives `sdram_req`=1 at T+1.
- `sdram_ack` at cycle A gives `sdram_req`=0 at A+1.
- `data_rdy` at cycle D gives `slot_ok`=1 and the new `slot_dout` at D+1, provided the address still matches.
- Back-to-back transactions: the next `sdram_req` can rise at D+2 at the earliest, since the FSM returns to IDLE at D+1.
- A hit shows `slot_ok` in the same cycle as the address change (zero latency).
- `sdram_addr` is stable for the whole of REQ and WAIT.

## Structure
- Package `jtkicker_sdram_arb_pkg` holds:
  - the state enum (IDLE, REQ, WAIT);
  - `NSLOT`=4;
  - `SLOT_MAIN`=0, `SLOT_SCR`=1, `SLOT_OBJ`=2, `SLOT_PCM`=3.
- Sub-module `jtkicker_sdram_arb_slot`, instantiated once per slot, holds the tag/data/valid registers, the hit comparator, and the fill/invalidate inputs.
- The top level contains the FSM, the arbiter and the address/offset mux.

## Test plan
- Single miss: slot 2 has `cs`=1, addr=0x0040, OFFSET2=0x10000. Expect `sdram_req` at T+1 with `sdram_addr`=0x10040. After ack, drive `data_rdy` with 0xBEEF; expect `slot_ok[2]`=1 and dout 0xBEEF one cycle later. A repeat read of 0x0040 produces no new `sdram_req`.
- Priority: slots 0, 1 and 3 miss together. Grant order must be 0, 1, 3. If slot 0 misses again after the first fill, the order becomes 0, 1, 0, 3.
- Round-robin fairness: slots 1–3 miss continuously with new addresses each time. Over 9 transactions each slot must get exactly 3 grants, in the order 1, 2, 3, 1, 2, 3, …
- Address change mid-transaction: slot 1 requests 0x0100, then switches to 0x0200 during WAIT. The fill writes tag 0x0100 and `slot_ok[1]` stays 0. A second request for 0x0200 is then issued.
- Download: fill all four slots, then pulse `downloading` for 5 cycles, one of them during an in-flight WAIT. Expect all `slot_ok`=0, no `sdram_req` while high, and the in-flight fill not marked valid.
- Reset mid-REQ: pull `rst_n` low while `sdram_req`=1. `sdram_req` must fall without waiting for a clock edge, and all `valid` bits must be 0 after release.
